traffic_intersection_ctrl: RTL and testbench
============================================

Name: traffic_intersection_ctrl

Overview:
- Timed phase scheduler for a two-road intersection: main road (N–S) and side road (E–W).
- Shares right-of-way between the two roads under side-road vehicle-sensor and pedestrian-button requests.
- Drives both light heads and the pedestrian walk lamp; sits directly above the light drivers in the intersection subsystem.

Parameters:
- TW, 8, timer width in bits
- GREEN_MAIN_CYC, 20, minimum main-green duration in clk cycles
- GREEN_SIDE_CYC, 10, fixed side-green duration in clk cycles
- YELLOW_CYC, 4, yellow duration for either road
- ALLRED_CYC, 2, all-red clearance duration
- Constraint: every *_CYC is in 1..2^TW; out-of-range values are illegal.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- car_side  in  1  side-road vehicle sensor, level
- ped_req  in  1  pedestrian button, level or pulse
- emerg  in  1  emergency-vehicle preempt request; present only when EMERG_PREEMPT_EN is defined
- light_main  out  2  main-road head: 00 RED, 01 GREEN, 10 YELLOW
- light_side  out  2  side-road head, same encoding
- walk  out  1  walk lamp for crossing the main road
- ped_pending  out  1  pedestrian request latched, not yet served
- state_dbg  out  3  current state code

Behaviour:
- Reset is asynchronous, active-high, clock is clk. During reset:
  - state = ALLRED_2
  - timer = ALLRED_CYC-1
  - light_main = light_side = 00
  - walk = 0, ped_pending = 0
- State codes:
  - 0 MAIN_GREEN, 1 MAIN_YELLOW, 2 ALLRED_1, 3 SIDE_GREEN, 4 SIDE_YELLOW, 5 ALLRED_2
  - Codes 6 and 7 are illegal; they recover to ALLRED_2 on the next clock with lights RED.
- Lights are Moore-decoded from the registered state:
  - MAIN_GREEN: main 01, side 00
  - MAIN_YELLOW: main 10, side 00
  - SIDE_GREEN: main 00, side 01
  - SIDE_YELLOW: main 00, side 10
  - ALLRED_1 / ALLRED_2: both 00
  - Never both roads non-RED.
- Timer:
  - On state entry, load D-1, where D is the phase's *_CYC value.
  - Decrement each cycle; saturate at 0.
  - "Expired" means timer==0. A phase of duration D therefore lasts exactly D cycles when its exit is unconditional.
- Transitions:
  - MAIN_GREEN → MAIN_YELLOW when expired AND (car_side OR ped_pending). Otherwise hold, timer remaining 0; exit is then possible on the first cycle a request is present.
  - MAIN_YELLOW → ALLRED_1 on expiry.
  - ALLRED_1 → SIDE_GREEN on expiry.
  - SIDE_GREEN → SIDE_YELLOW on expiry; car_side is ignored here.
  - SIDE_YELLOW → ALLRED_2 on expiry.
  - ALLRED_2 → MAIN_GREEN on expiry.
- Pedestrian request:
  - ped_pending is set the cycle after ped_req=1 is sampled in any state except while walk=1.
  - On the ALLRED_1 → SIDE_GREEN edge: walk <= ped_pending | ped_req, and ped_pending <= 0 (clear wins).
  - walk clears on the SIDE_GREEN → SIDE_YELLOW edge, so it is high for exactly GREEN_SIDE_CYC cycles, aligned with side GREEN.
  - ped_req while walk=1 is ignored.
- Full cycle with continuous demand at defaults: 20+4+2+10+4+2 = 42 cycles.
- Reset mid-operation: immediate return to reset values; the pending pedestrian request is lost.

Optional Feature:
- Macro: EMERG_PREEMPT_EN
- Defined: emerg port exists.
  - While emerg=1, MAIN_GREEN never exits.
  - SIDE_GREEN exits to SIDE_YELLOW on the next clock regardless of timer; walk drops on that edge.
  - ALLRED_1 on expiry goes to ALLRED_2 (timer reloaded) instead of SIDE_GREEN; ped_pending is retained.
  - Yellow and ALLRED_2 phases are never shortened.
- Undefined: no emerg port; behaviour exactly as above.

Test Plan:
- Reset released, all inputs 0 → both lights 00 for 2 cycles, then light_main=01 held for ≥100 cycles; state_dbg=0.
- car_side pulsed high for 1 cycle at main-green cycle 5 → request not latched, no exit. car_side held high from cycle 5 → main green lasts 20 cycles, then main 10 ×4, all-red ×2, side 01 ×10, side 10 ×4, all-red ×2, main 01.
- ped_req 1-cycle pulse in MAIN_GREEN (car_side=0) → ped_pending=1 next cycle; sequence runs; walk=1 for exactly 10 cycles coincident with side 01; ped_pending=0 from the side-green entry edge.
- car_side constantly 1 → light_main=01 entry recurs every 42 cycles; ped_req asserted while walk=1 → ped_pending stays 0.
- Async reset asserted at side-green cycle 3 with walk=1 → same-instant lights 00, walk=0, ped_pending=0; after release, 2 all-red cycles then main 01.
- (EMERG_PREEMPT_EN) emerg=1 at side-green cycle 2 → side 10 next cycle ×4, all-red ×2, main 01 held while emerg=1. emerg=1 in ALLRED_1 → next phase ALLRED_2, side stays 00.

Source files
------------

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: timed main/side phase scheduler with pedestrian walk service.
// Optional EMERG_PREEMPT_EN adds the emerg preempt input.
module traffic_intersection_ctrl #(
    parameter int TW             = 8,
    parameter int GREEN_MAIN_CYC = 20,
    parameter int GREEN_SIDE_CYC = 10,
    parameter int YELLOW_CYC     = 4,
    parameter int ALLRED_CYC     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_side,
    input  logic       ped_req,
`ifdef EMERG_PREEMPT_EN
    input  logic       emerg,
`endif
    output logic [1:0] light_main,
    output logic [1:0] light_side,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALLRED_1    = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALLRED_2    = 3'd5
    } state_t;
    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          expired, serve, walk_n, ped_n, emg;
`ifdef EMERG_PREEMPT_EN
    assign emg = emerg;
`else
    assign emg = 1'b0;
`endif
    assign expired = timer == '0;
    function automatic logic [TW-1:0] load(input state_t s);
        return s == MAIN_GREEN ? TW'(GREEN_MAIN_CYC - 1) :
               s == SIDE_GREEN ? TW'(GREEN_SIDE_CYC - 1) :
               (s == MAIN_YELLOW || s == SIDE_YELLOW) ? TW'(YELLOW_CYC - 1) :
               TW'(ALLRED_CYC - 1);
    endfunction
    always_comb begin
        state_n = state;
        case (state)
            MAIN_GREEN:  if (expired && (car_side || ped_pending) && !emg) state_n = MAIN_YELLOW;
            MAIN_YELLOW: if (expired) state_n = ALLRED_1;
            ALLRED_1:    if (expired) state_n = emg ? ALLRED_2 : SIDE_GREEN;
            SIDE_GREEN:  if (expired || emg) state_n = SIDE_YELLOW;
            SIDE_YELLOW: if (expired) state_n = ALLRED_2;
            ALLRED_2:    if (expired) state_n = MAIN_GREEN;
            default:     state_n = ALLRED_2;
        endcase
        timer_n = state_n != state ? load(state_n) : expired ? timer : timer - TW'(1);
        // The pending request (or one arriving on this very edge) is served as walk.
        serve  = state == ALLRED_1 && state_n == SIDE_GREEN;
        walk_n = serve ? (ped_pending | ped_req) :
                 (state == SIDE_GREEN && state_n == SIDE_YELLOW) ? 1'b0 : walk;
        ped_n  = serve ? 1'b0 : (ped_req && !walk) ? 1'b1 : ped_pending;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ALLRED_2;
            timer       <= TW'(ALLRED_CYC - 1);
            walk        <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            walk        <= walk_n;
            ped_pending <= ped_n;
        end
    end
    assign light_main = state == MAIN_GREEN ? 2'b01 : state == MAIN_YELLOW ? 2'b10 : 2'b00;
    assign light_side = state == SIDE_GREEN ? 2'b01 : state == SIDE_YELLOW ? 2'b10 : 2'b00;
    assign state_dbg  = state;
endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb_traffic_intersection_ctrl: directed stimulus checked every cycle against a phase/elapsed-time model.
module tb_traffic_intersection_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       car_side = 1'b0;
    logic       ped_req = 1'b0;
    logic       emerg = 1'b0;
    logic [1:0] light_main, light_side;
    logic       walk, ped_pending;
    logic [2:0] state_dbg;
    int pass_cnt = 0;
    int total_cnt = 0;

    traffic_intersection_ctrl dut (
        .clk(clk),
        .reset(reset),
        .car_side(car_side),
        .ped_req(ped_req),
`ifdef EMERG_PREEMPT_EN
        .emerg(emerg),
`endif
        .light_main(light_main),
        .light_side(light_side),
        .walk(walk),
        .ped_pending(ped_pending),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Phase order main-green, main-yellow, allred1, side-green, side-yellow, allred2.
    int  dur[6] = '{20, 4, 2, 10, 4, 2};
    int  ph = 5;
    int  el = 0;
    int  nxt;
    bit  m_ped = 0, m_walk = 0, done, adv, old_walk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task model_step();
        if (reset) begin
            ph = 5; el = 0; m_ped = 0; m_walk = 0;
        end else begin
            done = el >= dur[ph] - 1;
            adv  = ph == 0 ? (done && (car_side || m_ped) && !emerg) :
                   ph == 3 ? (done || emerg) : done;
            nxt  = (ph == 2 && emerg) ? 5 : (ph + 1) % 6;
            old_walk = m_walk;
            if (adv && ph == 2 && nxt == 3) begin
                m_walk = m_ped | ped_req;
                m_ped  = 0;
            end else begin
                if (adv && ph == 3) m_walk = 0;
                if (ped_req && !old_walk) m_ped = 1;
            end
            if (adv) begin ph = nxt; el = 0; end
            else el++;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    always @(negedge clk) begin
        chk("cmp_main", int'(light_main), ph == 0 ? 1 : ph == 1 ? 2 : 0);
        chk("cmp_side", int'(light_side), ph == 3 ? 1 : ph == 4 ? 2 : 0);
        chk("cmp_walk", int'(walk), int'(m_walk));
        chk("cmp_ped", int'(ped_pending), int'(m_ped));
        chk("cmp_state", int'(state_dbg), ph);
        chk("never_both_go", int'(light_main != 2'b00 && light_side != 2'b00), 0);
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        step(3);
        chk("rst_main", int'(light_main), 0);
        chk("rst_side", int'(light_side), 0);
        chk("rst_walk", int'(walk), 0);
        chk("rst_ped", int'(ped_pending), 0);
        chk("rst_state", int'(state_dbg), 5);
        reset = 1'b0;
        chk("rel_ar0", int'(light_main), 0);
        step(1); chk("rel_ar1", int'(light_main), 0);
        step(1); chk("rel_main_go", int'(light_main), 1); chk("rel_state0", int'(state_dbg), 0);
        // One-cycle car pulse before expiry must not cause an exit.
        step(4); car_side = 1'b1;
        step(1); car_side = 1'b0;
        step(100); chk("hold100", int'(light_main), 1);
        ped_req = 1'b1;
        step(1); ped_req = 1'b0;
        chk("ped_latched", int'(ped_pending), 1);
        chk("ped_main_still", int'(light_main), 1);
        step(1); chk("ped_yellow", int'(light_main), 2);
        step(6); chk("walk_side_go", int'(light_side), 1); chk("walk_on", int'(walk), 1);
        chk("ped_cleared", int'(ped_pending), 0);
        step(9); chk("walk_last", int'(walk), 1);
        step(1); chk("walk_off", int'(walk), 0); chk("side_yellow", int'(light_side), 2);
        step(6); chk("main_again", int'(light_main), 1);
        step(4); car_side = 1'b1;
        step(15); chk("main_cyc20", int'(light_main), 1);
        step(1); chk("main_yel_after20", int'(light_main), 2);
        step(21); chk("pre_period_ar", int'(light_main), 0);
        step(1); chk("period42", int'(light_main), 1);
        ped_req = 1'b1;
        step(1); ped_req = 1'b0;
        chk("ped_latched2", int'(ped_pending), 1);
        step(26); chk("walk_on2", int'(walk), 1);
        ped_req = 1'b1;
        step(4); ped_req = 1'b0;
        chk("ped_ignored", int'(ped_pending), 0);
        step(11); chk("main_again2", int'(light_main), 1);
        ped_req = 1'b1;
        step(1); ped_req = 1'b0;
        step(27); chk("walk_pre_rst", int'(walk), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_main", int'(light_main), 0);
        chk("arst_side", int'(light_side), 0);
        chk("arst_walk", int'(walk), 0);
        chk("arst_ped", int'(ped_pending), 0);
        chk("arst_state", int'(state_dbg), 5);
        car_side = 1'b0;
        step(1); reset = 1'b0;
        chk("rel2_ar0", int'(light_main), 0);
        step(1); chk("rel2_ar1", int'(light_main), 0);
        step(1); chk("rel2_main_go", int'(light_main), 1);
`ifdef EMERG_PREEMPT_EN
        car_side = 1'b1;
        step(27); chk("em_side_go", int'(light_side), 1);
        emerg = 1'b1;
        step(1); chk("em_side_yel", int'(light_side), 2); chk("em_walk", int'(walk), 0);
        step(52); chk("em_main_hold", int'(light_main), 1);
        emerg = 1'b0;
        step(6); chk("em_ar1", int'(state_dbg), 2);
        emerg = 1'b1;
        step(1); chk("em_ar2", int'(state_dbg), 5); chk("em_side_red", int'(light_side), 0);
        emerg = 1'b0;
        step(2); chk("em_main_back", int'(light_main), 1);
`endif
        step(5);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
